// File: rtl/debug_request_sequencer.sv
// Host-side debug dump sequencer: polls each debug controller in turn and
// streams the captured frames MSB-byte-first to the UART transmitter.
module debug_request_sequencer #(
    parameter int               NB_CONTROL_FRAME = 32,
    parameter int               NB_BYTE          = 8,
    parameter int               NB_ID            = 6,
    parameter int               N_CONTROLLERS    = 4,
    parameter logic [NB_ID-1:0] IDLE_ID          = {NB_ID{1'b1}},
    parameter int               TIMEOUT_CYCLES   = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_controller,
    input  logic                        i_writing,
    input  logic                        i_tx_ready,
    output logic [NB_ID-1:0]            o_request_select,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_valid,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout_err
);

    localparam int N_BYTES = NB_CONTROL_FRAME / NB_BYTE;
    localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int NB_CNT  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
    localparam logic [NB_CNT-1:0]  CNT_LAST  = NB_CNT'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_ID-1:0]   LAST_ID   = NB_ID'(N_CONTROLLERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [NB_ID-1:0]            id_q, id_d;
    logic [NB_BIDX-1:0]          byte_idx_q, byte_idx_d;
    logic [NB_CNT-1:0]           cnt_q, cnt_d;
    logic [NB_CONTROL_FRAME-1:0] frame_q, frame_d;
    logic                        timeout_err_q, timeout_err_d;
    logic [NB_ID-1:0]            req_sel_q, req_sel_d;
    logic                        tx_valid_q, tx_valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        tx_accept;

    assign tx_accept = tx_valid_q & i_tx_ready;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        byte_idx_d    = byte_idx_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    id_d          = '0;
                    byte_idx_d    = '0;
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                    state_d       = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // A real frame arriving on the expiry cycle still wins.
                if (i_writing) begin
                    frame_d = i_frame_from_controller;
                    state_d = ST_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    frame_d       = '1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_accept) begin
                    frame_d    = frame_q << NB_BYTE;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        if (id_q == LAST_ID) begin
                            state_d = ST_DONE;
                        end else begin
                            id_d    = id_q + 1'b1;
                            cnt_d   = '0;
                            state_d = ST_REQUEST;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_sel_d  = (state_d == ST_REQUEST) ? id_d : IDLE_ID;
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            id_q          <= '0;
            byte_idx_q    <= '0;
            cnt_q         <= '0;
            frame_q       <= '0;
            timeout_err_q <= 1'b0;
            req_sel_q     <= IDLE_ID;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            byte_idx_q    <= byte_idx_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            timeout_err_q <= timeout_err_d;
            req_sel_q     <= req_sel_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_request_select = req_sel_q;
    assign o_tx_data        = frame_q[NB_CONTROL_FRAME-1 -: NB_BYTE];
    assign o_tx_valid       = tx_valid_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_timeout_err    = timeout_err_q;

endmodule
